bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 79 +++++++
 tb/tb_bcd_to_bin.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential eight-digit packed-BCD to binary converter, one digit per cycle, MSD first.
// Digits above 9 are still accumulated, and they raise the err flag that is returned with the result.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] bin_out,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [31:0] shreg;
  logic [31:0] acc;
  logic        err_acc;
  logic [2:0]  cnt;

  logic [3:0]  digit;
  logic [31:0] acc_next;
  logic        err_next;

  // acc*10 as two shifts and an add; any overflow wraps modulo 2^32.
  always_comb begin
    digit    = shreg[31:28];
    acc_next = (acc << 3) + (acc << 1) + {28'd0, digit};
    err_next = err_acc | (digit > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      err_acc <= 1'b0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            shreg   <= bcd_in;
            acc     <= '0;
            err_acc <= 1'b0;
            cnt     <= 3'd7;
            state   <= CONV;
          end else begin
            state   <= IDLE;
          end
        end
        CONV: begin
          acc     <= acc_next;
          err_acc <= err_next;
          shreg   <= shreg << 4;
          cnt     <= cnt - 3'd1;
          // The last digit is folded straight into the visible result on entry to FIN.
          if (cnt == 3'd0) begin
            bin_out <= acc_next;
            err     <= err_next;
            state   <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CONV);
  assign done      = (state == FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and random checks of bcd_to_bin against a decimal reference model.
// Covers timing, result hold, ignored starts, abort by reset, and chained starts.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bcd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] bin_out;
  logic        err;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_bin = '0;
  logic        last_err = 1'b0;

  bcd_to_bin dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal reference: weighted sum of the raw nibbles, wrapping at 32 bits.
  function automatic logic [32:0] ref_conv(input logic [31:0] bcd);
    logic [31:0] r;
    logic        e;
    int unsigned d;
    r = '0;
    e = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      d = (bcd >> (4 * k)) & 32'hF;
      r = r * 32'd10 + d;
      if (d > 9) e = 1'b1;
    end
    return {e, r};
  endfunction

  // Call from a cycle in which the DUT can accept start (IDLE or FIN), #1 after an edge.
  // Returns in the FIN cycle if chain=1, otherwise one cycle later.
  // pulse_at>0 raises start with junk data during CONV cycle T+pulse_at.
  task automatic do_conv(input logic [31:0] bcd, input bit chain, input int pulse_at);
    logic [32:0] exp;
    exp = ref_conv(bcd);
    start  = 1'b1;
    bcd_in = bcd;
    step();
    start  = 1'b0;
    bcd_in = $urandom;
    for (int i = 1; i <= 8; i++) begin
      chk("busy_conv", {31'd0, busy}, 32'd1);
      chk("done_conv", {31'd0, done}, 32'd0);
      chk("bin_hold", bin_out, last_bin);
      chk("err_hold", {31'd0, err}, {31'd0, last_err});
      if (i == pulse_at) begin
        start  = 1'b1;
        bcd_in = 32'h0000_0456;
      end
      step();
      start  = 1'b0;
      bcd_in = $urandom;
    end
    chk("done_fin", {31'd0, done}, 32'd1);
    chk("busy_fin", {31'd0, busy}, 32'd0);
    chk("bin_out", bin_out, exp[31:0]);
    chk("err", {31'd0, err}, {31'd0, exp[32]});
    last_bin = exp[31:0];
    last_err = exp[32];
    if (!chain) begin
      step();
      chk("done_after", {31'd0, done}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("bin_keep", bin_out, last_bin);
    end
  endtask

  initial begin
    logic [31:0] r;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bin", bin_out, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    // A start coinciding with reset is ignored.
    start  = 1'b1;
    bcd_in = 32'h1234_5678;
    step();
    rst    = 1'b0;
    start  = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    step();
    chk("rst_start_busy2", {31'd0, busy}, 32'd0);

    do_conv(32'h0000_0000, 1'b0, 0);
    do_conv(32'h1234_5678, 1'b0, 0);
    chk("val_12345678", bin_out, 32'h00BC_614E);
    do_conv(32'h9999_9999, 1'b0, 0);
    chk("val_99999999", bin_out, 32'h05F5_E0FF);
    do_conv(32'h0000_000A, 1'b0, 0);
    chk("err_0a", {31'd0, err}, 32'd1);
    do_conv(32'h0000_0042, 1'b0, 0);
    chk("val_42", bin_out, 32'h0000_002A);
    do_conv(32'hFFFF_FFFF, 1'b0, 0);

    // Start during CONV is ignored; start in FIN chains the next conversion.
    do_conv(32'h0000_0123, 1'b1, 4);
    chk("val_7b", bin_out, 32'h0000_007B);
    do_conv(32'h0000_0456, 1'b0, 0);
    chk("val_1c8", bin_out, 32'h0000_01C8);

    // Reset mid-conversion aborts without a done pulse.
    start  = 1'b1;
    bcd_in = 32'h0000_0999;
    step();
    start  = 1'b0;
    for (int i = 1; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_bin = '0;
    last_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_bin", bin_out, 32'd0);
      step();
    end

    // Random back-to-back conversions, mixing legal BCD and arbitrary words.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        r = '0;
        for (int k = 0; k < 8; k++) r = (r << 4) | 32'($urandom_range(9, 0));
      end else begin
        r = $urandom;
      end
      do_conv(r, ($urandom_range(1, 0) == 1), 0);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
